// File: rtl/guess_pkg.sv
// rtl/guess_pkg.sv - shared encodings for the guess-number round sequencer
package guess_pkg;

    // Phase codes are also driven out to the display mux, so keep them stable.
    typedef enum logic [2:0] {
        PH_IDLE       = 3'd0,
        PH_GEN        = 3'd1,
        PH_SET_SECRET = 3'd2,
        PH_GUESS      = 3'd3,
        PH_COMPARE    = 3'd4,
        PH_RESULT     = 3'd5,
        PH_DONE       = 3'd6
    } phase_e;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_NEW   = 4'hC;
    localparam logic [3:0] BLANK     = 4'hF;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/guess_secret_gen.sv
// rtl/guess_secret_gen.sv - LFSR-driven generator of a secret with distinct decimal digits
module guess_secret_gen
    import guess_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    gen_done,
    output logic [4*NUM_DIGITS-1:0] secret
);

    logic [7:0]              lfsr_q, lfsr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [15:0]             used_q, used_d;
    logic [4*NUM_DIGITS-1:0] buf_q, buf_d;
    logic [3:0]              nib;

    assign nib      = lfsr_q[3:0];
    assign gen_done = done_q;
    assign secret   = buf_q;

    // LFSR steps every cycle; while busy, accept each fresh decimal nibble into the next slot.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        used_d = used_q;
        buf_d  = buf_q;
        if (start) begin
            // A restart abandons any fill in progress, including one finishing this cycle.
            busy_d = 1'b1;
            cnt_d  = 3'd0;
            used_d = '0;
            buf_d  = '1;
        end else if (busy_q && is_digit(nib) && !used_q[nib]) begin
            used_d[nib] = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (3'(i) == cnt_q) buf_d[4*(NUM_DIGITS-1-i) +: 4] = nib;
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(NUM_DIGITS - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Generator state registers; the LFSR never sees zero because it starts from a nonzero seed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= 3'd0;
            used_q <= '0;
            buf_q  <= '1;
        end else begin
            lfsr_q <= lfsr_d;
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            used_q <= used_d;
            buf_q  <= buf_d;
        end
    end

endmodule

// File: rtl/guess_round_ctrl.sv
// rtl/guess_round_ctrl.sv - round sequencer: key entry, compare, attempt count, win/loss
module guess_round_ctrl
    import guess_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int MAX_TRIES     = 10,
    parameter int REVEAL_CYCLES = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic                    setter_mode,
    input  logic [2:0]              match_a,
    input  logic [2:0]              match_b,
    output logic [4*NUM_DIGITS-1:0] secret_o,
    output logic [4*NUM_DIGITS-1:0] guess_o,
    output logic [2:0]              entry_cnt,
    output logic [2:0]              phase,
    output logic [2:0]              res_a,
    output logic [2:0]              res_b,
    output logic                    cmp_valid,
    output logic [3:0]              tries,
    output logic                    win,
    output logic                    lose,
    output logic                    err
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int RW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
    localparam logic [RW-1:0] REVEAL_LAST = RW'(REVEAL_CYCLES - 1);
    localparam logic [2:0]    FULL        = 3'(NUM_DIGITS);
    localparam logic [3:0]    LAST_TRY    = 4'(MAX_TRIES);

    phase_e          state_q, state_d;
    logic [BW-1:0]   secret_q, secret_d;
    logic [BW-1:0]   guess_q, guess_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [2:0]      res_a_q, res_a_d;
    logic [2:0]      res_b_q, res_b_d;
    logic            cmp_valid_q, cmp_valid_d;
    logic [3:0]      tries_q, tries_d;
    logic            win_q, win_d;
    logic            lose_q, lose_d;
    logic            err_q, err_d;
    logic [RW-1:0]   reveal_q, reveal_d;

    logic            key_new;
    logic            dup;
    logic            gen_start;
    logic            gen_done;
    logic [BW-1:0]   gen_secret;

    assign key_new   = key_valid && (key_code == KEY_NEW);
    assign gen_start = key_new && !setter_mode;

    guess_secret_gen #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_gen (
        .clk      (clk),
        .rst      (rst),
        .start    (gen_start),
        .gen_done (gen_done),
        .secret   (gen_secret)
    );

    // Blank nibbles are 4'hF and can never equal a digit, so scanning the whole buffer is safe.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (guess_q[4*i +: 4] == key_code) dup = 1'b1;
        end
    end

    // Next-state logic: new game overrides everything, otherwise the phase decides.
    always_comb begin
        state_d     = state_q;
        secret_d    = secret_q;
        guess_d     = guess_q;
        cnt_d       = cnt_q;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        cmp_valid_d = 1'b0;
        tries_d     = tries_q;
        win_d       = win_q;
        lose_d      = lose_q;
        err_d       = 1'b0;
        reveal_d    = reveal_q;
        if (key_new) begin
            state_d  = setter_mode ? PH_SET_SECRET : PH_GEN;
            secret_d = '1;
            guess_d  = '1;
            cnt_d    = 3'd0;
            res_a_d  = 3'd0;
            res_b_d  = 3'd0;
            tries_d  = 4'd0;
            win_d    = 1'b0;
            lose_d   = 1'b0;
        end else begin
            unique case (state_q)
                PH_GEN: begin
                    if (gen_done) begin
                        secret_d = gen_secret;
                        state_d  = PH_GUESS;
                    end
                end
                PH_SET_SECRET, PH_GUESS: begin
                    if (key_valid) begin
                        if (is_digit(key_code)) begin
                            if (cnt_q == FULL || dup) begin
                                err_d = 1'b1;
                            end else begin
                                for (int i = 0; i < NUM_DIGITS; i++) begin
                                    if (3'(i) == cnt_q) guess_d[4*(NUM_DIGITS-1-i) +: 4] = key_code;
                                end
                                cnt_d = cnt_q + 3'd1;
                            end
                        end else if (key_code == KEY_BACK) begin
                            if (cnt_q == 3'd0) begin
                                err_d = 1'b1;
                            end else begin
                                for (int i = 0; i < NUM_DIGITS; i++) begin
                                    if (3'(i) + 3'd1 == cnt_q) guess_d[4*(NUM_DIGITS-1-i) +: 4] = BLANK;
                                end
                                cnt_d = cnt_q - 3'd1;
                            end
                        end else if (key_code == KEY_ENTER) begin
                            if (cnt_q != FULL) begin
                                err_d = 1'b1;
                            end else if (state_q == PH_SET_SECRET) begin
                                secret_d = guess_q;
                                guess_d  = '1;
                                cnt_d    = 3'd0;
                                state_d  = PH_GUESS;
                            end else begin
                                state_d = PH_COMPARE;
                            end
                        end
                    end
                end
                PH_COMPARE: begin
                    // Match is combinational on the held buffers, so its result is valid here.
                    res_a_d     = match_a;
                    res_b_d     = match_b;
                    cmp_valid_d = 1'b1;
                    tries_d     = tries_q + 4'd1;
                    if (match_a == FULL) begin
                        win_d   = 1'b1;
                        state_d = PH_DONE;
                    end else if (tries_q + 4'd1 == LAST_TRY) begin
                        lose_d  = 1'b1;
                        state_d = PH_DONE;
                    end else begin
                        reveal_d = '0;
                        state_d  = PH_RESULT;
                    end
                end
                PH_RESULT: begin
                    if (reveal_q == REVEAL_LAST) begin
                        guess_d = '1;
                        cnt_d   = 3'd0;
                        state_d = PH_GUESS;
                    end else begin
                        reveal_d = reveal_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // All round state and the registered outputs, cleared together so reset leaves no residue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PH_IDLE;
            secret_q    <= '1;
            guess_q     <= '1;
            cnt_q       <= 3'd0;
            res_a_q     <= 3'd0;
            res_b_q     <= 3'd0;
            cmp_valid_q <= 1'b0;
            tries_q     <= 4'd0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            err_q       <= 1'b0;
            reveal_q    <= '0;
        end else begin
            state_q     <= state_d;
            secret_q    <= secret_d;
            guess_q     <= guess_d;
            cnt_q       <= cnt_d;
            res_a_q     <= res_a_d;
            res_b_q     <= res_b_d;
            cmp_valid_q <= cmp_valid_d;
            tries_q     <= tries_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            err_q       <= err_d;
            reveal_q    <= reveal_d;
        end
    end

    assign secret_o  = secret_q;
    assign guess_o   = guess_q;
    assign entry_cnt = cnt_q;
    assign phase     = state_q;
    assign res_a     = res_a_q;
    assign res_b     = res_b_q;
    assign cmp_valid = cmp_valid_q;
    assign tries     = tries_q;
    assign win       = win_q;
    assign lose      = lose_q;
    assign err       = err_q;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// tb/tb_guess_round_ctrl.sv - scoreboard bench for guess_round_ctrl
module tb_guess_round_ctrl;
    import guess_pkg::*;

    localparam int ND = 4;
    localparam int MT = 2;
    localparam int RC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        setter_mode = 1'b1;
    logic [2:0]  match_a, match_b;
    logic [15:0] secret_o, guess_o;
    logic [2:0]  entry_cnt, phase, res_a, res_b;
    logic        cmp_valid, win, lose, err;
    logic [3:0]  tries;

    always #5 clk = ~clk;

    guess_round_ctrl #(
        .NUM_DIGITS    (ND),
        .MAX_TRIES     (MT),
        .REVEAL_CYCLES (RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .setter_mode (setter_mode),
        .match_a     (match_a),
        .match_b     (match_b),
        .secret_o    (secret_o),
        .guess_o     (guess_o),
        .entry_cnt   (entry_cnt),
        .phase       (phase),
        .res_a       (res_a),
        .res_b       (res_b),
        .cmp_valid   (cmp_valid),
        .tries       (tries),
        .win         (win),
        .lose        (lose),
        .err         (err)
    );

    // Stand-in for the Match datapath.
    always_comb begin
        match_a = 3'd0;
        match_b = 3'd0;
        for (int i = 0; i < ND; i++)
            for (int j = 0; j < ND; j++)
                if (secret_o[4*i +: 4] != 4'hF && secret_o[4*i +: 4] == guess_o[4*j +: 4]) begin
                    if (i == j) match_a = match_a + 3'd1;
                    else        match_b = match_b + 3'd1;
                end
    end

    typedef struct { int a; int b; int t; int w; int l; } cmp_t;
    cmp_t cmp_q[$];
    int   err_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic [4:0] prev_key = 5'd0;

    phase_e m_phase;
    int     m_ent[ND];
    int     m_sec[ND];
    int     m_n, m_tries, m_a, m_b;
    bit     m_sec_set, m_win, m_lose;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [15:0] pack(input int d[ND], input int n);
        logic [15:0] r = '1;
        for (int i = 0; i < ND; i++)
            if (i < n) r[4*(ND-1-i) +: 4] = 4'(d[i]);
        return r;
    endfunction

    always @(posedge clk) prev_key <= {key_valid, key_code};

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (err) begin
                chk("err_expected", int'(err_q.size() > 0), 1);
                if (err_q.size() > 0) chk("err_key", int'(prev_key), 16 + err_q.pop_front());
            end
            if (cmp_valid) begin
                chk("cmp_expected", int'(cmp_q.size() > 0), 1);
                if (cmp_q.size() > 0) begin
                    cmp_t c;
                    c = cmp_q.pop_front();
                    chk("cmp_res_a", res_a, c.a);
                    chk("cmp_res_b", res_b, c.b);
                    chk("cmp_tries", tries, c.t);
                    chk("cmp_win", win, c.w);
                    chk("cmp_lose", lose, c.l);
                end
            end
        end
    end

    task automatic model_reset();
        m_phase = PH_IDLE; m_n = 0; m_sec_set = 0;
        m_tries = 0; m_a = 0; m_b = 0; m_win = 0; m_lose = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_phase"}, phase, int'(m_phase));
        chk({tag, "_guess"}, guess_o, pack(m_ent, m_n));
        chk({tag, "_entry_cnt"}, entry_cnt, m_n);
        chk({tag, "_secret"}, secret_o, m_sec_set ? pack(m_sec, ND) : 16'hFFFF);
        chk({tag, "_tries"}, tries, m_tries);
        chk({tag, "_win"}, win, m_win);
        chk({tag, "_lose"}, lose, m_lose);
        chk({tag, "_res_a"}, res_a, m_a);
        chk({tag, "_res_b"}, res_b, m_b);
    endtask

    task automatic model_key(input int k);
        bit dupl;
        int a, b;
        if (k == KEY_NEW) begin
            m_n = 0; m_sec_set = 0; m_tries = 0; m_a = 0; m_b = 0; m_win = 0; m_lose = 0;
            m_phase = setter_mode ? PH_SET_SECRET : PH_GEN;
        end else if (m_phase == PH_SET_SECRET || m_phase == PH_GUESS) begin
            if (k <= 9) begin
                dupl = 0;
                for (int i = 0; i < m_n; i++) if (m_ent[i] == k) dupl = 1;
                if (m_n == ND || dupl) err_q.push_back(k);
                else begin m_ent[m_n] = k; m_n++; end
            end else if (k == KEY_BACK) begin
                if (m_n == 0) err_q.push_back(k);
                else m_n--;
            end else if (k == KEY_ENTER) begin
                if (m_n < ND) err_q.push_back(k);
                else if (m_phase == PH_SET_SECRET) begin
                    m_sec = m_ent; m_sec_set = 1; m_n = 0; m_phase = PH_GUESS;
                end else begin
                    a = 0; b = 0;
                    for (int i = 0; i < ND; i++)
                        for (int j = 0; j < ND; j++)
                            if (m_sec[i] == m_ent[j]) begin
                                if (i == j) a++; else b++;
                            end
                    m_tries++; m_a = a; m_b = b;
                    if (a == ND) begin m_win = 1; m_phase = PH_DONE; end
                    else if (m_tries == MT) begin m_lose = 1; m_phase = PH_DONE; end
                    else m_phase = PH_RESULT;
                    cmp_q.push_back('{a, b, m_tries, int'(m_win), int'(m_lose)});
                end
            end
        end
    endtask

    task automatic press(input int k);
        model_key(k);
        @(posedge clk); #1 key_valid = 1'b1; key_code = 4'(k);
        @(posedge clk); #1 key_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("err_missing", err_q.size(), 0);
        chk("cmp_missing", cmp_q.size(), 0);
        check_state("key");
    endtask

    task automatic press4(input logic [15:0] v);
        for (int i = 0; i < ND; i++) press(int'(v[4*(ND-1-i) +: 4]));
    endtask

    task automatic wait_reveal();
        int n = 0;
        while (phase != 3'(PH_GUESS) && n < 40) begin @(posedge clk); #1; n++; end
        chk("reveal_len", n, RC - 1);
        m_n = 0; m_phase = PH_GUESS;
        check_state("reveal");
    endtask

    task automatic wait_gen();
        int n = 0;
        bit ok = 1;
        int d;
        while (phase != 3'(PH_GUESS) && n < 64) begin @(posedge clk); #1; n++; end
        chk("gen_in_time", int'(phase == 3'(PH_GUESS)), 1);
        for (int i = 0; i < ND; i++) begin
            d = int'(secret_o[4*(ND-1-i) +: 4]);
            if (d > 9) ok = 0;
            for (int j = 0; j < i; j++) if (m_sec[j] == d) ok = 0;
            m_sec[i] = d;
        end
        chk("gen_digits_distinct", int'(ok), 1);
        m_sec_set = 1; m_phase = PH_GUESS;
        check_state("gen");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int pool[10];
        int r, t;
        bit seen;
        #1 rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset_err", err, 0);
        chk("reset_cmp_valid", cmp_valid, 0);
        @(negedge clk) rst = 1'b1;

        // 1: setter types 1234 and guesses it at once.
        setter_mode = 1'b1;
        press(KEY_NEW); press4(16'h1234); press(KEY_ENTER);
        chk("t1_secret", secret_o, 16'h1234);
        press4(16'h1234); press(KEY_ENTER);
        chk("t1_res_a", res_a, 4);
        chk("t1_win", win, 1);
        chk("t1_tries", tries, 1);
        chk("t1_phase", phase, int'(PH_DONE));
        press(5);

        // 2: all-B guess goes through the reveal window.
        press(KEY_NEW); press4(16'h1234); press(KEY_ENTER);
        press4(16'h4321); press(KEY_ENTER);
        chk("t2_res_a", res_a, 0);
        chk("t2_res_b", res_b, 4);
        chk("t2_phase", phase, int'(PH_RESULT));
        wait_reveal();
        chk("t2_guess_blank", guess_o, 16'hFFFF);

        // 3: entry errors.
        press(5); press(5);
        chk("t3_entry_cnt", entry_cnt, 1);
        press(KEY_BACK); press(KEY_BACK); press(4'hD);
        press(1); press(2); press(3); press(KEY_ENTER);
        chk("t3_phase", phase, int'(PH_GUESS));

        // 4: loss on the last try, then a win on the last try.
        press(KEY_NEW); press4(16'h1234); press(KEY_ENTER);
        press4(16'h5678); press(KEY_ENTER); wait_reveal();
        press4(16'h8765); press(KEY_ENTER);
        chk("t4_lose", lose, 1);
        press(KEY_NEW); press4(16'h1234); press(KEY_ENTER);
        press4(16'h5678); press(KEY_ENTER); wait_reveal();
        press4(16'h1234); press(KEY_ENTER);
        chk("t4_win", win, 1);
        chk("t4_lose_clear", lose, 0);

        // 5: generated secret, and a new game landing on gen_done.
        setter_mode = 1'b0;
        press(KEY_NEW); wait_gen();
        press(KEY_NEW);
        seen = 0;
        for (int n = 0; n < 80 && !seen; n++) begin
            @(negedge clk);
            if (dut.gen_done) seen = 1;
        end
        chk("t5_done_seen", int'(seen), 1);
        if (seen) begin
            model_key(KEY_NEW);
            key_valid = 1'b1; key_code = KEY_NEW;
            @(posedge clk); #1 key_valid = 1'b0;
            chk("t5_stay_gen", phase, int'(PH_GEN));
            chk("t5_secret_blank", secret_o, 16'hFFFF);
        end
        wait_gen();

        // 6: asynchronous reset mid-guess.
        setter_mode = 1'b1;
        press(KEY_NEW); press4(16'h9876); press(KEY_ENTER); press(1); press(2);
        @(posedge clk); #3 rst = 1'b0;
        #1;
        model_reset();
        check_state("t6");
        chk("t6_err", err, 0);
        chk("t6_cmp_valid", cmp_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Random games.
        for (int g = 0; g < 12; g++) begin
            setter_mode = 1'($urandom_range(0, 1));
            press(KEY_NEW);
            if (!setter_mode) wait_gen();
            else begin
                for (int i = 0; i < 10; i++) pool[i] = i;
                for (int i = 0; i < ND; i++) begin
                    r = $urandom_range(i, 9);
                    t = pool[i]; pool[i] = pool[r]; pool[r] = t;
                    press(pool[i]);
                end
                press(KEY_ENTER);
            end
            for (int s = 0; s < 40 && m_phase != PH_DONE; s++) begin
                r = $urandom_range(0, 99);
                if (r < 8 && m_n == 0) begin
                    for (int i = 0; i < ND; i++) press(m_sec[i]);
                    press(KEY_ENTER);
                end else if (r < 70) press($urandom_range(0, 9));
                else if (r < 80) press(KEY_BACK);
                else if (r < 94) press(KEY_ENTER);
                else press($urandom_range(13, 15));
                if (m_phase == PH_RESULT) wait_reveal();
            end
            press($urandom_range(0, 9));
        end

        chk("final_err_q", err_q.size(), 0);
        chk("final_cmp_q", cmp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
